// File: rtl/osd_console_if.sv
// Character-stream and text-buffer write bus of the on-screen-display console.
interface osd_console_if;
  logic [7:0] char_in;
  logic       char_valid;
  logic       char_ready;
  logic       clear;
  logic       busy;
  logic [7:0] address;
  logic [7:0] data;
  logic       wren;
  logic [4:0] cursor_x;
  logic [2:0] cursor_y;

  modport master (
    output char_in, char_valid, clear,
    input  char_ready, busy, address, data, wren, cursor_x, cursor_y
  );

  modport slave (
    input  char_in, char_valid, clear,
    output char_ready, busy, address, data, wren, cursor_x, cursor_y
  );
endinterface

// File: rtl/osd_console.sv
// Text console: turns a character stream into text-buffer writes, tracks the
// cursor and inverse attribute, and blanks lines / the whole screen.
module osd_console #(
  parameter int         COLS  = 32,
  parameter int         ROWS  = 8,
  parameter logic [7:0] BLANK = 8'h20
) (
  input  logic          clk,
  input  logic          rst_n,
  osd_console_if.slave  bus
);

  localparam int             CW        = $clog2(COLS);
  localparam int             RW        = $clog2(ROWS);
  localparam logic [CW-1:0]  COL_LAST  = CW'(COLS - 1);
  localparam logic [7:0]     CELL_LAST = 8'hFF;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PUT       = 2'd1,
    FILL_LINE = 2'd2,
    FILL_ALL  = 2'd3
  } state_t;

  state_t        state_r, state_s;
  logic [7:0]    cnt_r, cnt_s;
  logic [CW-1:0] cx_r, cx_s;
  logic [RW-1:0] cy_r, cy_s;
  logic          inv_r, inv_s;
  logic          pend_r, pend_s;
  logic          wren_r, wren_s;
  logic [7:0]    addr_r, addr_s;
  logic [7:0]    data_r, data_s;
  logic          accept_s;
  logic          clear_req_s;

  // Clear wins over a coincident character, so it blocks ready combinationally.
  assign bus.char_ready = (state_r == IDLE) && !pend_r && !bus.clear;
  assign accept_s       = bus.char_ready && bus.char_valid;
  assign clear_req_s    = pend_r || bus.clear;
  assign bus.busy       = (state_r != IDLE) || pend_r;
  assign bus.address    = addr_r;
  assign bus.data       = data_r;
  assign bus.wren       = wren_r;
  assign bus.cursor_x   = 5'(cx_r);
  assign bus.cursor_y   = 3'(cy_r);

  // Next-state, cursor and write-port decode.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    cx_s    = cx_r;
    cy_s    = cy_r;
    inv_s   = inv_r;
    pend_s  = pend_r;
    wren_s  = 1'b0;
    addr_s  = addr_r;
    data_s  = data_r;
    case (state_r)
      IDLE: begin
        if (bus.clear) begin
          state_s = FILL_ALL;
          cnt_s   = 8'd0;
        end else if (accept_s) begin
          if (bus.char_in >= 8'h20) begin
            wren_s = 1'b1;
            addr_s = {cy_r, cx_r};
            data_s = {inv_r, bus.char_in[6:0]};
            if (cx_r == COL_LAST) begin
              cx_s    = '0;
              cy_s    = cy_r + RW'(1);
              cnt_s   = 8'd0;
              state_s = FILL_LINE;
            end else begin
              cx_s    = cx_r + CW'(1);
              state_s = PUT;
            end
          end else begin
            case (bus.char_in)
              8'h0D: cx_s = '0;
              8'h0A: begin
                cy_s    = cy_r + RW'(1);
                cnt_s   = 8'd0;
                state_s = FILL_LINE;
              end
              8'h08: begin
                if (cx_r != '0) begin
                  cx_s = cx_r - CW'(1);
                end else begin
                  cx_s = cx_r;
                end
              end
              8'h0E: inv_s = 1'b1;
              8'h0F: inv_s = 1'b0;
              8'h0C: begin
                state_s = FILL_ALL;
                cnt_s   = 8'd0;
              end
              default: state_s = IDLE;
            endcase
          end
        end else begin
          state_s = IDLE;
        end
      end
      PUT: begin
        if (clear_req_s) begin
          state_s = FILL_ALL;
          cnt_s   = 8'd0;
          pend_s  = 1'b0;
        end else begin
          state_s = IDLE;
        end
      end
      FILL_LINE: begin
        wren_s = 1'b1;
        addr_s = {cy_r, cnt_r[CW-1:0]};
        data_s = BLANK;
        cnt_s  = cnt_r + 8'd1;
        pend_s = clear_req_s;
        if (cnt_r[CW-1:0] == COL_LAST) begin
          if (clear_req_s) begin
            state_s = FILL_ALL;
            cnt_s   = 8'd0;
            pend_s  = 1'b0;
          end else begin
            state_s = IDLE;
          end
        end else begin
          state_s = FILL_LINE;
        end
      end
      FILL_ALL: begin
        // Clears arriving here are already satisfied by this fill.
        wren_s = 1'b1;
        addr_s = cnt_r;
        data_s = BLANK;
        cnt_s  = cnt_r + 8'd1;
        pend_s = 1'b0;
        if (cnt_r == CELL_LAST) begin
          cx_s    = '0;
          cy_s    = '0;
          state_s = IDLE;
        end else begin
          state_s = FILL_ALL;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State and output registers; reset lands in a full-screen fill.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= FILL_ALL;
      cnt_r   <= 8'd0;
      cx_r    <= '0;
      cy_r    <= '0;
      inv_r   <= 1'b0;
      pend_r  <= 1'b0;
      wren_r  <= 1'b0;
      addr_r  <= 8'd0;
      data_r  <= 8'd0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      cx_r    <= cx_s;
      cy_r    <= cy_s;
      inv_r   <= inv_s;
      pend_r  <= pend_s;
      wren_r  <= wren_s;
      addr_r  <= addr_s;
      data_r  <= data_s;
    end
  end

endmodule

// File: tb/tb_osd_console.sv
// Randomised scoreboard bench for osd_console with a cursor/screen reference model.
module tb_osd_console;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  osd_console_if bus();

  osd_console #(.COLS(32), .ROWS(8), .BLANK(8'h20)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [15:0] exp_q[$];
  logic [15:0] mon_exp;
  int          m_cx, m_cy;
  bit          m_inv;
  logic [7:0]  ctl_tab [10] = '{8'h0D, 8'h0A, 8'h08, 8'h08, 8'h0E,
                                8'h0F, 8'h0C, 8'h01, 8'h1B, 8'h00};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: cursor arithmetic plus the list of cells each code must write.
  function automatic void push_fill(input int base, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back({8'(base + i), 8'h20});
  endfunction

  function automatic void model_clear();
    push_fill(0, 256);
    m_cx = 0;
    m_cy = 0;
  endfunction

  function automatic void model_char(input logic [7:0] c);
    if (c >= 8'h20) begin
      exp_q.push_back({8'(m_cy * 32 + m_cx), m_inv, c[6:0]});
      m_cx++;
      if (m_cx == 32) begin
        m_cx = 0;
        m_cy = (m_cy + 1) % 8;
        push_fill(m_cy * 32, 32);
      end
    end else begin
      case (c)
        8'h0D: m_cx = 0;
        8'h0A: begin
          m_cy = (m_cy + 1) % 8;
          push_fill(m_cy * 32, 32);
        end
        8'h08: if (m_cx > 0) m_cx--;
        8'h0E: m_inv = 1'b1;
        8'h0F: m_inv = 1'b0;
        8'h0C: model_clear();
        default: ;
      endcase
    end
  endfunction

  // Monitor: every write strobe must match the head of the expected queue.
  always @(negedge clk) begin
    if (rst_n && bus.wren === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_write: got addr %0h data %0h, expected no write", bus.address, bus.data);
      end else begin
        mon_exp = exp_q.pop_front();
        check("write", {bus.address, bus.data}, mon_exp);
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (bus.char_ready !== 1'b1 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (bus.char_ready !== 1'b1) begin
      n_tests++;
      n_fail++;
      $display("FAIL ready_timeout: got char_ready %b, expected 1", bus.char_ready);
    end
  endtask

  task automatic send_char(input logic [7:0] c);
    wait_ready();
    bus.char_in    = c;
    bus.char_valid = 1'b1;
    @(posedge clk);
    model_char(c);
    @(negedge clk);
    bus.char_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (bus.busy !== 1'b0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (bus.busy !== 1'b0) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s_idle_timeout: got busy %b, expected 0", name, bus.busy);
    end
    @(negedge clk);
    check({name, "_pending_writes"}, exp_q.size(), 0);
    check({name, "_cursor_x"}, bus.cursor_x, m_cx);
    check({name, "_cursor_y"}, bus.cursor_y, m_cy);
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_wren"}, bus.wren, 0);
    check({name, "_address"}, bus.address, 0);
    check({name, "_data"}, bus.data, 0);
    check({name, "_char_ready"}, bus.char_ready, 0);
    check({name, "_busy"}, bus.busy, 1);
    check({name, "_cursor"}, {bus.cursor_y, bus.cursor_x}, 0);
  endtask

  initial begin
    logic [7:0] c;
    bus.char_in    = 8'h00;
    bus.char_valid = 1'b0;
    bus.clear      = 1'b0;
    m_cx = 0;
    m_cy = 0;
    m_inv = 1'b0;

    // Reset values, then the power-up blanking of all 256 cells.
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    push_fill(0, 256);
    rst_n = 1'b1;
    wait_idle("reset_fill");
    check("reset_ready", bus.char_ready, 1);

    // "A", inverse on, "B".
    send_char(8'h41);
    send_char(8'h0E);
    send_char(8'h42);
    wait_idle("chars");
    check("chars_cursor_x_const", bus.cursor_x, 2);
    send_char(8'h0F);

    // A full row of printables wraps and blanks the next row.
    send_char(8'h0D);
    for (int i = 0; i < 32; i++) send_char(8'($urandom_range(32, 126)));
    wait_idle("wrap");
    check("wrap_cursor_const", {bus.cursor_y, bus.cursor_x}, {3'd1, 5'd0});

    // LF on the last row wraps to row 0.
    repeat (6) send_char(8'h0A);
    send_char(8'h0D);
    repeat (5) send_char(8'($urandom_range(32, 126)));
    send_char(8'h0A);
    wait_idle("lf_wrap");
    check("lf_wrap_cursor_const", {bus.cursor_y, bus.cursor_x}, {3'd0, 5'd5});

    // Clear pulse in the third cycle of a line fill is deferred, not dropped.
    send_char(8'h0A);
    @(negedge clk);
    @(negedge clk);
    bus.clear = 1'b1;
    model_clear();
    @(negedge clk);
    bus.clear = 1'b0;
    check("clear_pending_busy", bus.busy, 1);
    wait_idle("clear_in_line");

    // BS at column 0 and a discarded control code.
    send_char(8'h08);
    check("bs_ready", bus.char_ready, 1);
    check("bs_wren", bus.wren, 0);
    check("bs_cursor", {bus.cursor_y, bus.cursor_x}, 0);
    send_char(8'h01);
    check("ctl01_ready", bus.char_ready, 1);
    check("ctl01_wren", bus.wren, 0);
    check("ctl01_cursor", {bus.cursor_y, bus.cursor_x}, 0);

    // Clear and a character together: clear wins, the character is refused.
    send_char(8'h41);
    wait_idle("pre_coincide");
    bus.char_in    = 8'h5A;
    bus.char_valid = 1'b1;
    bus.clear      = 1'b1;
    #1;
    check("coincide_ready", bus.char_ready, 0);
    @(posedge clk);
    model_clear();
    @(negedge clk);
    bus.clear      = 1'b0;
    bus.char_valid = 1'b0;
    wait_idle("coincide");

    // Random mix of printables and control codes.
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 99) < 70) c = 8'($urandom_range(32, 127));
      else c = ctl_tab[$urandom_range(0, 9)];
      send_char(c);
      if (i % 25 == 24) wait_idle("random");
    end
    wait_idle("random_end");

    // Reset asserted in the middle of a full fill.
    send_char(8'h0E);
    send_char(8'h0C);
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    exp_q.delete();
    m_cx = 0;
    m_cy = 0;
    m_inv = 1'b0;
    @(posedge clk);
    #1;
    check("midreset_hold_wren", bus.wren, 0);
    @(negedge clk);
    push_fill(0, 256);
    rst_n = 1'b1;
    wait_idle("midreset_fill");
    send_char(8'h43);
    wait_idle("post_reset_char");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/osd_console.md
OSD_CONSOLE -- requirements
Module: osd_console

Interface
REQ-001 SHALL have parameter COLS, default 32, meaning text columns per row (power of two).
REQ-002 SHALL have parameter ROWS, default 8, meaning text rows (power of two; COLS*ROWS = 256).
REQ-003 SHALL have parameter BLANK, default 8'h20, meaning character code written by clear operations.
REQ-004 SHALL have port clk, input, 1, the single clock; all logic is rising-edge.
REQ-005 SHALL have port rst_n, input, 1, reset, asynchronous and active-low.
REQ-006 SHALL have port char_in, input, 8, the character or control code offered.
REQ-007 SHALL have port char_valid, input, 1, meaning char_in is offered this cycle.
REQ-008 SHALL have port char_ready, output, 1, meaning a character can be accepted this cycle.
REQ-009 SHALL have port clear, input, 1, a single-cycle pulse that requests a clear-screen and home.
REQ-010 SHALL have port busy, output, 1, high while any write or fill sequence is active or pending.
REQ-011 SHALL have port address, output, 8, the text buffer write address, computed as row*COLS+col.
REQ-012 SHALL have port data, output, 8, the text buffer write data; bit7 is the inverse attribute.
REQ-013 SHALL have port wren, output, 1, the text buffer write strobe.
REQ-014 SHALL have port cursor_x, output, 5, the current column.
REQ-015 SHALL have port cursor_y, output, 3, the current row.

Function
REQ-016 SHALL implement states IDLE, PUT, FILL_LINE and FILL_ALL.
REQ-017 SHALL register address, data and wren, and SHALL deassert wren in every cycle without a write.
REQ-018 SHALL drive char_ready=1 only in IDLE with no pending clear; a transfer occurs at a rising edge where char_valid and char_ready are both 1.
REQ-019 SHALL treat codes 0x20-0x7F as printable; PUT then lasts one cycle with wren=1, address=cursor, data={inv,char_in[6:0]}.
REQ-020 SHALL make the first PUT write visible in the cycle after acceptance, giving a latency of 1.
REQ-021 SHALL, after a printable write, increment cursor_x; from COLS-1 it SHALL set cursor_x=0, set cursor_y=(cursor_y+1) mod ROWS, and enter FILL_LINE.
REQ-022 SHALL handle 0x0D (CR) by setting cursor_x=0, with no write; it returns to IDLE next cycle.
REQ-023 SHALL handle 0x0A (LF) by setting cursor_y=(cursor_y+1) mod ROWS with cursor_x unchanged, then entering FILL_LINE.
REQ-024 SHALL handle 0x08 (BS) by setting cursor_x=cursor_x-1 when cursor_x>0 (no change at 0), with no write.
REQ-025 SHALL handle 0x0E by setting inv=1 and 0x0F by setting inv=0, with no write.
REQ-026 SHALL handle 0x0C (FF) identically to a clear pulse.
REQ-027 SHALL accept and discard all other codes below 0x20 with no effect.
REQ-028 SHALL, in FILL_LINE, write BLANK to cells cursor_y*COLS+0 through +COLS-1, one per cycle, in COLS consecutive wren cycles, then return to IDLE.
REQ-029 SHALL, in FILL_ALL, write BLANK to addresses 0..255 ascending, one per cycle, in 256 consecutive cycles, then set the cursor to (0,0) and return to IDLE; inv is unchanged.
REQ-030 SHALL keep BLANK fill data free of the inverse attribute (bit7 = BLANK[7]).
REQ-031 SHALL latch a clear pulse arriving in any non-IDLE state as pending; the pending clear SHALL start FILL_ALL immediately after the current sequence ends.
REQ-032 SHALL give clear priority when clear and char_valid coincide in IDLE: char_ready is 0 that cycle, FILL_ALL starts, and the character is not accepted.
REQ-033 SHALL ignore a clear pulse during FILL_ALL, with no restart and nothing left pending.
REQ-034 SHALL drive busy = (state != IDLE) or clear pending.
REQ-035 SHALL use modulo arithmetic for all cursor and fill counters, and SHALL never emit an address above 255.

Reset
REQ-036 SHALL, while rst_n=0, drive wren=0, address=0, data=0, char_ready=0, busy=1, cursor=(0,0), inv=0, with no pending clear.
REQ-037 SHALL start FILL_ALL on the first clock edge after rst_n is released, so the screen is blank after 256 cycles.
REQ-038 SHALL force outputs to their reset values immediately when rst_n is asserted mid-sequence, with no further writes.

Verification
REQ-039 SHALL verify reset release: exactly 256 wren cycles occur with addresses 0..255 and data 0x20, then char_ready=1 and cursor=(0,0).
REQ-040 SHALL verify characters: "A", then 0x0E, then "B" -> writes (0,0x41) then (1,0xC2), and cursor_x=2.
REQ-041 SHALL verify wrap: 32 printable characters from (0,0) -> the last write goes to address 31, then 32 BLANK writes to addresses 32..63, and the cursor ends at (0,1).
REQ-042 SHALL verify LF at row 7, col 5 -> cursor=(5,0) and BLANK writes to addresses 0..31.
REQ-043 SHALL verify a clear pulse in FILL_LINE cycle 3 -> FILL_LINE completes all 32 writes, then 256 BLANK writes follow, then the cursor is at (0,0).
REQ-044 SHALL verify BS at col 0 and the control code 0x01 -> no wren and no cursor change; char_ready returns to 1 the next cycle.
